// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq -- sequential ALU execute stage
//
// Consumes the 4-bit ALU control code and two operands. add/sub/and/or/slt
// and unsupported codes complete on the start edge; mul (0011) runs a
// shift-add loop, one multiplier bit per cycle, for exactly WIDTH cycles.
//
// Ports:
//   clk_i      clock, rising edge
//   rst_i      synchronous active-high reset
//   start_i    launch an operation (ignored while busy_o=1)
//   ALUCtrl_i  operation code
//   src1_i     operand A
//   src2_i     operand B
//   busy_o     high while a multiply iterates
//   done_o     one-cycle pulse, result_o/zero_o/illegal_o just updated
//   result_o   registered result, held until next completion
//   zero_o     registered (result_o == 0)
//   illegal_o  registered, last completed op had an unsupported code
//
// State  | Meaning
// -------+--------------------------------------------------------------
// IDLE   | accepting start_i; single-cycle ops complete from here
// MUL    | shift-add multiply iterating, count_q cycles remaining
// ---------------------------------------------------------------------------
module alu_seq #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 7
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [3:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             illegal_o
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_MUL = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             illegal_q, illegal_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] single_res;
    logic             single_ill;
    logic [WIDTH-1:0] acc_sum;
    logic             last_iter;

    // State register (plus datapath registers)
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            count_q   <= '0;
            result_q  <= '0;
            zero_q    <= 1'b1;
            illegal_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            count_q   <= count_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
            done_q    <= done_d;
        end
    end

    assign last_iter = (count_q == CNT_ONE);

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start_i && (ALUCtrl_i == OP_MUL)) state_d = S_MUL;
            S_MUL:  if (last_iter) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Single-cycle result; illegal codes force a zero result
    always_comb begin
        single_res = '0;
        single_ill = 1'b0;
        case (ALUCtrl_i)
            OP_ADD: single_res = src1_i + src2_i;
            OP_SUB: single_res = src1_i - src2_i;
            OP_AND: single_res = src1_i & src2_i;
            OP_OR:  single_res = src1_i | src2_i;
            OP_SLT: single_res = {{(WIDTH-1){1'b0}},
                                  ($signed(src1_i) < $signed(src2_i))};
            default: single_ill = 1'b1;
        endcase
    end

    assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

    // Datapath / output next values
    always_comb begin
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        count_d   = count_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (ALUCtrl_i == OP_MUL) begin
                        acc_d    = '0;
                        mcand_d  = src1_i;
                        mplier_d = src2_i;
                        count_d  = CNT_INIT;
                    end else begin
                        result_d  = single_res;
                        zero_d    = (single_res == '0);
                        illegal_d = single_ill;
                        done_d    = 1'b1;
                    end
                end
            end
            S_MUL: begin
                acc_d    = acc_sum;
                mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                count_d  = count_q - CNT_ONE;
                // Completion uses this cycle's sum, not the stale acc_q
                if (last_iter) begin
                    result_d  = acc_sum;
                    zero_d    = (acc_sum == '0);
                    illegal_d = 1'b0;
                    done_d    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign busy_o    = (state_q == S_MUL);
    assign done_o    = done_q;
    assign result_o  = result_q;
    assign zero_o    = zero_q;
    assign illegal_o = illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq -- self-checking bench for alu_seq (WIDTH=64)
//
// Every accepted op pushes its expected result onto a queue; a negedge
// monitor pops and compares whenever done_o is seen. Single-cycle ops come
// from a vector table applied back-to-back; multiplies and the reset abort
// are driven as hand-written sequences.
// ---------------------------------------------------------------------------
module tb_alu_seq;

    localparam int W = 64;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         start_i;
    logic [3:0]   ALUCtrl_i;
    logic [W-1:0] src1_i;
    logic [W-1:0] src2_i;
    logic         busy_o;
    logic         done_o;
    logic [W-1:0] result_o;
    logic         zero_o;
    logic         illegal_o;

    alu_seq #(.WIDTH(W), .CNT_W(7)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .ALUCtrl_i (ALUCtrl_i),
        .src1_i    (src1_i),
        .src2_i    (src2_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .result_o  (result_o),
        .zero_o    (zero_o),
        .illegal_o (illegal_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0]   ctrl;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         z;
        logic         ill;
    } vec_t;

    typedef struct {
        logic [W-1:0] res;
        logic         z;
        logic         ill;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[12];

    int checks = 0;
    int errors = 0;
    int done_run = 0;
    int last_run = 0;
    int done_seen = 0;

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Scoreboard: pop one expectation per done_o pulse
    always @(negedge clk_i) begin
        if (done_o === 1'b1) begin
            exp_t e;
            done_run++;
            done_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done_o=1 expected no pending op");
            end else begin
                e = exp_q.pop_front();
                check("result", result_o, e.res);
                check("zero", {63'd0, zero_o}, {63'd0, e.z});
                check("illegal", {63'd0, illegal_o}, {63'd0, e.ill});
            end
        end else begin
            if (done_run > 0) last_run = done_run;
            done_run = 0;
        end
    end

    function automatic exp_t model(input logic [3:0] c, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        exp_t e;
        e.ill = 1'b0;
        case (c)
            4'b0010: e.res = a + b;
            4'b0110: e.res = a - b;
            4'b0000: e.res = a & b;
            4'b0001: e.res = a | b;
            4'b0111: e.res = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            4'b0011: e.res = a * b;
            default: begin e.res = '0; e.ill = 1'b1; end
        endcase
        e.z = (e.res == '0);
        return e;
    endfunction

    // Called at #1 after an edge; drives one start and consumes that edge.
    task automatic issue(input logic [3:0] c, input logic [W-1:0] a,
                         input logic [W-1:0] b, input exp_t e);
        start_i   = 1'b1;
        ALUCtrl_i = c;
        src1_i    = a;
        src2_i    = b;
        exp_q.push_back(e);
        @(posedge clk_i); #1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk_i); #1;
            n++;
        end
        check({name, "_drain_pending"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    // Start a mul, wait for done, check latency and busy length.
    task automatic run_mul(input string name, input logic [W-1:0] a,
                           input logic [W-1:0] b, input bit disturb);
        int cyc = 0;
        int busy_cnt = 0;
        bit got = 0;
        issue(4'b0011, a, b, model(4'b0011, a, b));
        start_i = 1'b0;
        cyc = 1;
        while (!got && cyc < 200) begin
            @(negedge clk_i);
            if (done_o) got = 1;
            else begin
                if (busy_o) busy_cnt++;
                cyc++;
                if (disturb) begin
                    start_i   = (cyc < 60) ? 1'($urandom_range(0, 1)) : 1'b0;
                    ALUCtrl_i = (cyc < 60) ? 4'b0010 : 4'b0000;
                    src1_i    = {$urandom, $urandom};
                    src2_i    = {$urandom, $urandom};
                end
            end
        end
        start_i = 1'b0;
        check({name, "_latency"}, 64'(cyc), 64'(W + 1));
        check({name, "_busy_cycles"}, 64'(busy_cnt), 64'(W));
        @(posedge clk_i); #1;
    endtask

    initial begin
        int seen0;
        logic [W-1:0] ra, rb;

        vecs[0]  = '{4'b0010, 64'd5, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 1'b1, 1'b0};
        vecs[1]  = '{4'b0110, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
        vecs[2]  = '{4'b0111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 1'b0, 1'b0};
        vecs[3]  = '{4'b0111, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0};
        vecs[4]  = '{4'b0000, 64'hF0F0, 64'hFF00, 64'hF000, 1'b0, 1'b0};
        vecs[5]  = '{4'b0001, 64'hF0F0, 64'h0F0F, 64'hFFFF, 1'b0, 1'b0};
        vecs[6]  = '{4'b1111, 64'd7, 64'd9, 64'd0, 1'b1, 1'b1};
        vecs[7]  = '{4'b0100, 64'd7, 64'd9, 64'd0, 1'b1, 1'b1};
        vecs[8]  = '{4'b0010, 64'd1, 64'd2, 64'd3, 1'b0, 1'b0};
        vecs[9]  = '{4'b0110, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
        vecs[10] = '{4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b0};
        vecs[11] = '{4'b0111, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF,
                     64'd1, 1'b0, 1'b0};

        rst_i = 1'b1; start_i = 1'b0; ALUCtrl_i = '0; src1_i = '0; src2_i = '0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_result", result_o, 64'd0);
        check("rst_zero", {63'd0, zero_o}, 64'd1);
        check("rst_busy", {63'd0, busy_o}, 64'd0);
        check("rst_done", {63'd0, done_o}, 64'd0);
        check("rst_illegal", {63'd0, illegal_o}, 64'd0);
        @(posedge clk_i); #1;

        // Back-to-back single-cycle vectors: done_o every cycle
        for (int i = 0; i < 12; i++) begin
            exp_t e;
            e.res = vecs[i].res; e.z = vecs[i].z; e.ill = vecs[i].ill;
            issue(vecs[i].ctrl, vecs[i].a, vecs[i].b, e);
        end
        start_i = 1'b0;
        drain("table");
        @(posedge clk_i); #1;
        check("b2b_done_run", 64'(last_run), 64'd12);

        // Isolated op: done_o exactly once, one cycle later
        seen0 = done_seen;
        issue(4'b0001, 64'h1, 64'h2, model(4'b0001, 64'h1, 64'h2));
        start_i = 1'b0;
        repeat (3) @(posedge clk_i); #1;
        check("single_done_count", 64'(done_seen - seen0), 64'd1);

        run_mul("mul_12345", 64'd12345, 64'd678, 1'b1);
        check("mul_12345_value", result_o, 64'd8369910);
        run_mul("mul_wrap", 64'h8000_0000_0000_0000, 64'd2, 1'b0);
        check("mul_wrap_zero", {63'd0, zero_o}, 64'd1);
        ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
        run_mul("mul_rand", ra, rb, 1'b0);
        run_mul("mul_ones", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        drain("mul");

        // Reset in the middle of a multiply: aborted, no done_o
        seen0 = done_seen;
        start_i = 1'b1; ALUCtrl_i = 4'b0011; src1_i = 64'd3; src2_i = 64'd4;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (20) @(posedge clk_i);
        #1 rst_i = 1'b1;
        @(posedge clk_i); #1 rst_i = 1'b0;
        @(negedge clk_i);
        check("abort_busy", {63'd0, busy_o}, 64'd0);
        check("abort_done", {63'd0, done_o}, 64'd0);
        check("abort_result", result_o, 64'd0);
        check("abort_zero", {63'd0, zero_o}, 64'd1);
        check("abort_illegal", {63'd0, illegal_o}, 64'd0);
        repeat (80) @(posedge clk_i); #1;
        check("abort_no_done", 64'(done_seen - seen0), 64'd0);

        // Illegal then legal add after reset
        issue(4'b1111, 64'd1, 64'd1, model(4'b1111, 64'd1, 64'd1));
        issue(4'b0010, 64'd40, 64'd2, model(4'b0010, 64'd40, 64'd2));
        start_i = 1'b0;
        drain("post_reset");
        check("final_illegal_cleared", {63'd0, illegal_o}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
